chaz_mem_arbiter: RTL and testbench

Single-port memory arbiter for the chaz SoC. Shares one synchronous RAM port between the Hazard3 instruction-fetch port, the Hazard3 data port and the debug loader port (dbg_*). The debug loader has absolute priority and holds a sticky session so a program load is never interleaved with CPU traffic. The block sits between the core bus ports and the RAM macro.

---
 rtl/chaz_bus_pkg.sv | 26 ++
 rtl/chaz_arb_rr2.sv | 33 +++
 rtl/chaz_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_chaz_mem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/chaz_bus_pkg.sv
// chaz_bus_pkg
//   Shared encodings for the chaz memory arbiter: read-response owner,
//   arbiter FSM states and the byte-to-word address slice.
package chaz_bus_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_DBG  = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        ST_CPU   = 2'd0,
        ST_DBG   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // RAM is word addressed; requesters use byte addresses.
    localparam int WORD_SHIFT = 2;

    function automatic int word_adr_w(input int addr_w);
        return addr_w - WORD_SHIFT;
    endfunction

endpackage

// File: rtl/chaz_arb_rr2.sv
// chaz_arb_rr2
//   Two-way round-robin picker. On a tie the requester not granted last wins.
//   The pointer only moves when i_en is high and a grant was made.
// Ports:
//   clk, reset        clock, async active-high reset
//   i_req_a, i_req_b  requests (a = instruction fetch, b = data)
//   i_en              pick is actually used this cycle; allows pointer update
//   o_gnt_a, o_gnt_b  one-hot (or zero) pick, combinational
module chaz_arb_rr2 (
    input  logic clk,
    input  logic reset,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_en,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    // 1 = b was granted last, so a wins the next tie (reset value).
    logic r_last_b;

    assign o_gnt_a = i_req_a & (~i_req_b | r_last_b);
    assign o_gnt_b = i_req_b & (~i_req_a | ~r_last_b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_b <= 1'b1;
        end else if (i_en && (o_gnt_a || o_gnt_b)) begin
            r_last_b <= o_gnt_b;
        end
    end

endmodule

// File: rtl/chaz_mem_arbiter.sv
// chaz_mem_arbiter
//   Shares one synchronous RAM port between instruction fetch (i_*), data (d_*)
//   and the debug loader (dbg_*). Debug has absolute priority and a sticky
//   session; CPU traffic resumes DBG_HOLD+1 cycles after dbg_req falls.
//   Optional feature macro: CHAZ_ARB_DBG_EN (undefined = I/D round-robin only,
//   dbg_* ignored, dbg outputs tied to 0).
// Ports:
//   clk, reset                         clock, async active-high reset
//   i_req/i_adr -> i_gnt/i_rvalid/i_rdata               fetch (read only)
//   d_req/d_wren/d_adr/d_wdata -> d_gnt/d_rvalid/d_rdata data, wren==0 is read
//   dbg_req/dbg_wren/dbg_adr/dbg_do -> dbg_gnt/dbg_rvalid/dbg_di  debug loader
//   mem_en/mem_wren/mem_adr/mem_wdata, mem_rdata        RAM port (1-cycle read)
//
// state    | meaning
// ST_CPU   | I/D round-robin; dbg_req takes the port this cycle
// ST_DBG   | debug session, only dbg may be granted
// ST_DRAIN | hold-off after a session; dbg may re-enter, CPU blocked
module chaz_mem_arbiter
    import chaz_bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DBG_HOLD = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_req,
    input  logic [ADDR_W-1:0]               i_adr,
    output logic                            i_gnt,
    output logic                            i_rvalid,
    output logic [31:0]                     i_rdata,
    input  logic                            d_req,
    input  logic [3:0]                      d_wren,
    input  logic [ADDR_W-1:0]               d_adr,
    input  logic [31:0]                     d_wdata,
    output logic                            d_gnt,
    output logic                            d_rvalid,
    output logic [31:0]                     d_rdata,
    input  logic                            dbg_req,
    input  logic [3:0]                      dbg_wren,
    input  logic [ADDR_W-1:0]               dbg_adr,
    input  logic [31:0]                     dbg_do,
    output logic                            dbg_gnt,
    output logic                            dbg_rvalid,
    output logic [31:0]                     dbg_di,
    output logic                            mem_en,
    output logic [3:0]                      mem_wren,
    output logic [word_adr_w(ADDR_W)-1:0]   mem_adr,
    output logic [31:0]                     mem_wdata,
    input  logic [31:0]                     mem_rdata
);

    logic   w_cpu_ok;
    logic   w_dbg_gnt;
    logic   w_pick_i;
    logic   w_pick_d;
    owner_e w_rd_own;
    owner_e r_own;
    logic   w_unused_lsb;

    assign w_unused_lsb = ^{i_adr[1:0], d_adr[1:0], dbg_adr[1:0]};

    chaz_arb_rr2 u_rr2 (
        .clk     (clk),
        .reset   (reset),
        .i_req_a (i_req),
        .i_req_b (d_req),
        .i_en    (w_cpu_ok),
        .o_gnt_a (w_pick_i),
        .o_gnt_b (w_pick_d)
    );

`ifdef CHAZ_ARB_DBG_EN
    state_e     r_state;
    logic [3:0] r_cnt;

    // Debug is granted whenever it asks, in every state; the FSM only
    // decides when the CPU may use the port again.
    assign w_dbg_gnt = dbg_req & ~reset;
    assign w_cpu_ok  = (r_state == ST_CPU) & ~dbg_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_CPU;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_CPU: begin
                    if (dbg_req) r_state <= ST_DBG;
                end
                ST_DBG: begin
                    if (!dbg_req) begin
                        r_cnt   <= 4'(DBG_HOLD);
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (dbg_req) begin
                        r_state <= ST_DBG;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        // <= also escapes a zero count rather than stalling
                        if (r_cnt <= 4'd1) r_state <= ST_CPU;
                    end
                end
                default: r_state <= ST_CPU;
            endcase
        end
    end

    assign dbg_gnt    = w_dbg_gnt;
    assign dbg_rvalid = (r_own == OWN_DBG);
    assign dbg_di     = mem_rdata;
`else
    logic w_unused_dbg;

    assign w_unused_dbg = ^{dbg_req, 4'(DBG_HOLD)};
    assign w_dbg_gnt    = 1'b0;
    assign w_cpu_ok     = 1'b1;
    assign dbg_gnt      = 1'b0;
    assign dbg_rvalid   = 1'b0;
    assign dbg_di       = 32'd0;
`endif

    assign i_gnt  = w_pick_i & w_cpu_ok & ~reset;
    assign d_gnt  = w_pick_d & w_cpu_ok & ~reset;
    assign mem_en = w_dbg_gnt | i_gnt | d_gnt;

    always_comb begin
        mem_adr   = '0;
        mem_wren  = 4'd0;
        mem_wdata = 32'd0;
        w_rd_own  = OWN_NONE;
        if (w_dbg_gnt) begin
            mem_adr   = dbg_adr[ADDR_W-1:WORD_SHIFT];
            mem_wren  = dbg_wren;
            mem_wdata = dbg_do;
            if (dbg_wren == 4'd0) w_rd_own = OWN_DBG;
        end else if (i_gnt) begin
            mem_adr  = i_adr[ADDR_W-1:WORD_SHIFT];
            w_rd_own = OWN_I;
        end else if (d_gnt) begin
            mem_adr   = d_adr[ADDR_W-1:WORD_SHIFT];
            mem_wren  = d_wren;
            mem_wdata = d_wdata;
            if (d_wren == 4'd0) w_rd_own = OWN_D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_own <= OWN_NONE;
        else       r_own <= w_rd_own;
    end

    assign i_rvalid = (r_own == OWN_I);
    assign d_rvalid = (r_own == OWN_D);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_chaz_mem_arbiter.sv
module tb_chaz_mem_arbiter;
    import chaz_bus_pkg::*;

    localparam int ADDR_W   = 32;
    localparam int DBG_HOLD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_adr, i_rdata;
    logic        d_req, d_gnt, d_rvalid;
    logic [3:0]  d_wren;
    logic [31:0] d_adr, d_wdata, d_rdata;
    logic        dbg_req, dbg_gnt, dbg_rvalid;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr, dbg_do, dbg_di;
    logic        mem_en;
    logic [3:0]  mem_wren;
    logic [29:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    always #5 clk = ~clk;

    chaz_mem_arbiter #(.ADDR_W(ADDR_W), .DBG_HOLD(DBG_HOLD)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_adr(i_adr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wren(d_wren), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .dbg_req(dbg_req), .dbg_wren(dbg_wren), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_di(dbg_di),
        .mem_en(mem_en), .mem_wren(mem_wren), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] mem_val(input logic [29:0] w);
        if (w == 30'h8000) return 32'h00010537;
        return {w[15:0], 16'h0} ^ {2'b0, w} ^ 32'h5A5A_0000;
    endfunction

    // RAM model: 1-cycle read latency
    always @(posedge clk) begin
        if (mem_en && mem_wren == 4'd0) mem_rdata <= mem_val(mem_adr);
    end

    typedef struct packed {
        logic [1:0]  own;
        logic [31:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // One clock: check expected response and expected grant at the negedge,
    // queue the read response a granted read must produce next cycle.
    task automatic tick(input logic [1:0] exp_own);
        rsp_t       e;
        logic [1:0] rsp_own;
        logic [31:0] rsp_data;
        @(negedge clk);
        rsp_own  = OWN_NONE;
        rsp_data = 32'd0;
        if (sb.size() > 0) begin
            e        = sb.pop_front();
            rsp_own  = e.own;
            rsp_data = e.data;
        end
        chk("i_rvalid", i_rvalid, rsp_own == OWN_I);
        chk("d_rvalid", d_rvalid, rsp_own == OWN_D);
        chk("dbg_rvalid", dbg_rvalid, rsp_own == OWN_DBG);
        if (rsp_own == OWN_I)   chk("i_rdata", i_rdata, rsp_data);
        if (rsp_own == OWN_D)   chk("d_rdata", d_rdata, rsp_data);
        if (rsp_own == OWN_DBG) chk("dbg_di", dbg_di, rsp_data);
`ifndef CHAZ_ARB_DBG_EN
        chk("dbg_di_off", dbg_di, 0);
`endif
        chk("i_gnt", i_gnt, exp_own == OWN_I);
        chk("d_gnt", d_gnt, exp_own == OWN_D);
        chk("dbg_gnt", dbg_gnt, exp_own == OWN_DBG);
        chk("mem_en", mem_en, exp_own != OWN_NONE);
        case (exp_own)
            OWN_I: begin
                chk("mem_adr_i", mem_adr, i_adr[31:2]);
                chk("mem_wren_i", mem_wren, 0);
                sb.push_back('{own: OWN_I, data: mem_val(i_adr[31:2])});
            end
            OWN_D: begin
                chk("mem_adr_d", mem_adr, d_adr[31:2]);
                chk("mem_wren_d", mem_wren, d_wren);
                if (d_wren != 4'd0) chk("mem_wdata_d", mem_wdata, d_wdata);
                else sb.push_back('{own: OWN_D, data: mem_val(d_adr[31:2])});
            end
            OWN_DBG: begin
                chk("mem_adr_dbg", mem_adr, dbg_adr[31:2]);
                chk("mem_wren_dbg", mem_wren, dbg_wren);
                if (dbg_wren != 4'd0) chk("mem_wdata_dbg", mem_wdata, dbg_do);
                else sb.push_back('{own: OWN_DBG, data: mem_val(dbg_adr[31:2])});
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        i_req = 1'b1; i_adr = 32'h0;
        d_req = 1'b0; d_wren = 4'd0; d_adr = 32'h0; d_wdata = 32'h0;
        dbg_req = 1'b0; dbg_wren = 4'd0; dbg_adr = 32'h0; dbg_do = 32'h0;

        // no grants while in reset even with a request pending
        tick(OWN_NONE);
        tick(OWN_NONE);
        reset = 1'b0;
        i_req = 1'b0;

        // single fetch
        i_req = 1'b1; i_adr = 32'h0002_0000;
        tick(OWN_I);
        i_req = 1'b0;
        tick(OWN_NONE);

        // data write: no read response
        d_req = 1'b1; d_wren = 4'hF; d_adr = 32'h0001_0004; d_wdata = 32'h55;
        tick(OWN_D);
        d_req = 1'b0;
        tick(OWN_NONE);

        // tie: last grant was D, so I,D,I,D,I,D
        i_req = 1'b1; d_req = 1'b1; d_wren = 4'd0;
        for (int k = 0; k < 6; k++) begin
            i_adr = 32'h100 + 32'(4 * k);
            d_adr = 32'h2000 + 32'(4 * k);
            tick((k % 2 == 0) ? OWN_I : OWN_D);
        end
        i_req = 1'b0; d_req = 1'b0;
        tick(OWN_NONE);

`ifdef CHAZ_ARB_DBG_EN
        // debug session blocks a held fetch
        i_req = 1'b1; i_adr = 32'h300;
        dbg_req = 1'b1; dbg_wren = 4'hF;
        for (int k = 0; k < 6; k++) begin
            dbg_adr = 32'h0002_0000 + 32'(4 * k);
            dbg_do  = 32'hA000 + 32'(k);
            tick(OWN_DBG);
        end
        dbg_wren = 4'd0; dbg_adr = 32'h0002_0008;
        tick(OWN_DBG);
        dbg_req = 1'b0;
        for (int k = 0; k < DBG_HOLD + 1; k++) tick(OWN_NONE);
        tick(OWN_I);

        // re-entry on the 2nd drain cycle
        dbg_req = 1'b1; dbg_wren = 4'hF; dbg_adr = 32'h0002_0040;
        tick(OWN_DBG);
        tick(OWN_DBG);
        dbg_req = 1'b0;
        tick(OWN_NONE);
        tick(OWN_NONE);
        dbg_req = 1'b1;
        tick(OWN_DBG);
        dbg_req = 1'b0;
        tick(OWN_NONE);
        tick(OWN_NONE);

        // reset during drain with a debug read outstanding: CPU resumes at once
        dbg_req = 1'b1; dbg_wren = 4'd0; dbg_adr = 32'h0002_0044;
        tick(OWN_DBG);
        reset = 1'b1; dbg_req = 1'b0;
        sb.delete();
        tick(OWN_NONE);
        reset = 1'b0;
        tick(OWN_I);
        i_req = 1'b0;
        tick(OWN_NONE);
`else
        // debug port disabled: dbg_req is ignored
        dbg_req = 1'b1; dbg_wren = 4'd0; dbg_adr = 32'h0002_0000;
        i_req = 1'b1; i_adr = 32'h400;
        tick(OWN_I);
        i_req = 1'b0;
        tick(OWN_NONE);
        dbg_req = 1'b0;
`endif

        // fetch granted, reset before its response: response dropped
        i_req = 1'b1; i_adr = 32'h0002_0000;
        tick(OWN_I);
        reset = 1'b1;
        sb.delete();
        tick(OWN_NONE);
        reset = 1'b0;
        i_adr = 32'h0002_0004;
        tick(OWN_I);
        i_req = 1'b0;
        tick(OWN_NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
